// File: rtl/sprite_dma_pkg.sv
// Shared types and defaults for the sprite DMA engine: FSM encodings,
// transfer-mode constants and default bus widths.
package sprite_dma_pkg;

   localparam int DEF_AS_W  = 10;
   localparam int DEF_AD_W  = 10;
   localparam int DEF_D_W   = 8;
   localparam int DEF_LEN_W = 11;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_LATCH  = 3'd2,
      ST_WRITE  = 3'd3,
      ST_FINISH = 3'd4
   } dma_state_e;

   // States in which a bus access is pending; these honour WAIT and ABORT.
   function automatic logic is_xfer_state(input dma_state_e s);
      return (s == ST_READ) || (s == ST_LATCH) || (s == ST_WRITE);
   endfunction

endpackage

// File: rtl/dma_edge_det.sv
// Rising-edge detector with synchronous clear. After a clear the input must
// be seen low once before an edge is reported, so a level held through clear is ignored.
module dma_edge_det (
   input  logic clk,
   input  logic clr,
   input  logic sig,
   output logic rise
);

   logic prev_q, prev_d;
   logic armed_q, armed_d;

   always_comb begin
      prev_d  = sig;
      armed_d = armed_q | ~sig;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         armed_q <= armed_d;
      end
   end

   assign rise = sig & ~prev_q & armed_q;

endmodule

// File: rtl/sprite_dma_engine.sv
// Single-channel sprite DMA: copies work RAM to the sprite buffer (3 cycles
// per element) or fills the buffer with a constant (1 cycle per element).
module sprite_dma_engine
   import sprite_dma_pkg::*;
#(
   parameter int AS_W  = DEF_AS_W,
   parameter int AD_W  = DEF_AD_W,
   parameter int D_W   = DEF_D_W,
   parameter int LEN_W = DEF_LEN_W
) (
   input  logic             I_CLK,
   input  logic             I_RSTn,
   input  logic             I_DMA_TRIG,
   input  logic             I_MODE,
   input  logic [AS_W-1:0]  I_SRC_BASE,
   input  logic [AD_W-1:0]  I_DST_BASE,
   input  logic [LEN_W-1:0] I_LEN,
   input  logic [D_W-1:0]   I_FILL,
   input  logic             I_ABORT,
   input  logic             I_WAIT,
   input  logic [D_W-1:0]   I_DMA_DS,
   output logic [AS_W-1:0]  O_DMA_AS,
   output logic             O_DMA_CES,
   output logic [AD_W-1:0]  O_DMA_AD,
   output logic [D_W-1:0]   O_DMA_DD,
   output logic             O_DMA_WED,
   output logic             O_BUSY,
   output logic             O_DONE
);

   dma_state_e state_q, state_d;

   logic             mode_q, mode_d;
   logic [AS_W-1:0]  src_ptr_q, src_ptr_d, as_hold_q, as_hold_d;
   logic [AD_W-1:0]  dst_ptr_q, dst_ptr_d, ad_hold_q, ad_hold_d;
   logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, cnt_inc;
   logic [D_W-1:0]   fill_q, fill_d, data_q, data_d, dd_hold_q, dd_hold_d;
   logic [D_W-1:0]   wr_data;

   logic rst_clr, trig_rise, accept, active, abort_act, go, last_elem;

   assign rst_clr = ~I_RSTn;

   dma_edge_det u_trig_edge (
      .clk  (I_CLK),
      .clr  (rst_clr),
      .sig  (I_DMA_TRIG),
      .rise (trig_rise)
   );

   // go: an access state that is neither stalled nor aborted this cycle
   always_comb begin
      active    = is_xfer_state(state_q);
      accept    = (state_q == ST_IDLE) && trig_rise;
      abort_act = active && I_ABORT;
      go        = active && !I_WAIT && !I_ABORT;
      cnt_inc   = cnt_q + LEN_W'(1);
      last_elem = (cnt_inc == len_q);
      wr_data   = (mode_q == MODE_COPY) ? data_q : fill_q;
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge I_CLK) begin
      if (!I_RSTn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (I_LEN == '0)              state_d = ST_FINISH;
               else if (I_MODE == MODE_FILL) state_d = ST_WRITE;
               else                          state_d = ST_READ;
            end
         end
         ST_READ:  if (go) state_d = ST_LATCH;
         ST_LATCH: if (go) state_d = ST_WRITE;
         ST_WRITE: begin
            if (go) begin
               if (last_elem)                state_d = ST_FINISH;
               else if (mode_q == MODE_FILL) state_d = ST_WRITE;
               else                          state_d = ST_READ;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      // Abort overrides a stall as well as normal sequencing.
      if (abort_act) state_d = ST_FINISH;
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      O_DMA_CES = (state_q == ST_READ)  && go;
      O_DMA_WED = (state_q == ST_WRITE) && go;
      O_DMA_AS  = (state_q == ST_READ)  ? src_ptr_q : as_hold_q;
      O_DMA_AD  = (state_q == ST_WRITE) ? dst_ptr_q : ad_hold_q;
      O_DMA_DD  = (state_q == ST_WRITE) ? wr_data   : dd_hold_q;
      O_BUSY    = active;
      O_DONE    = (state_q == ST_FINISH);
   end

   // ---------------- datapath ----------------
   always_comb begin
      mode_d    = mode_q;
      src_ptr_d = src_ptr_q;
      dst_ptr_d = dst_ptr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      fill_d    = fill_q;
      data_d    = data_q;
      as_hold_d = as_hold_q;
      ad_hold_d = ad_hold_q;
      dd_hold_d = dd_hold_q;

      if (accept) begin
         mode_d    = I_MODE;
         src_ptr_d = I_SRC_BASE;
         dst_ptr_d = I_DST_BASE;
         len_d     = I_LEN;
         fill_d    = I_FILL;
         cnt_d     = '0;
      end

      if (go) begin
         unique case (state_q)
            ST_READ:  as_hold_d = src_ptr_q;
            ST_LATCH: data_d    = I_DMA_DS;
            ST_WRITE: begin
               ad_hold_d = dst_ptr_q;
               dd_hold_d = wr_data;
               // Pointers wrap naturally at their widths.
               src_ptr_d = src_ptr_q + AS_W'(1);
               dst_ptr_d = dst_ptr_q + AD_W'(1);
               cnt_d     = cnt_inc;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge I_CLK) begin
      if (!I_RSTn) begin
         mode_q    <= MODE_COPY;
         src_ptr_q <= '0;
         dst_ptr_q <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         fill_q    <= '0;
         data_q    <= '0;
         as_hold_q <= '0;
         ad_hold_q <= '0;
         dd_hold_q <= '0;
      end else begin
         mode_q    <= mode_d;
         src_ptr_q <= src_ptr_d;
         dst_ptr_q <= dst_ptr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         fill_q    <= fill_d;
         data_q    <= data_d;
         as_hold_q <= as_hold_d;
         ad_hold_q <= ad_hold_d;
         dd_hold_q <= dd_hold_d;
      end
   end

endmodule

// File: tb/tb_sprite_dma_engine.sv
// Bench for sprite_dma_engine: table of transfers checked by a write scoreboard,
// plus hand sequences for reset mid-transfer and trigger held through reset.
module tb_sprite_dma_engine;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       I_RSTn = 1'b0;
   logic       I_DMA_TRIG = 1'b0;
   logic       I_MODE = 1'b0;
   logic [9:0] I_SRC_BASE = '0;
   logic [9:0] I_DST_BASE = '0;
   logic [10:0] I_LEN = '0;
   logic [7:0] I_FILL = '0;
   logic       I_ABORT = 1'b0;
   logic       I_WAIT = 1'b0;
   logic [7:0] I_DMA_DS = '0;
   logic [9:0] O_DMA_AS;
   logic       O_DMA_CES;
   logic [9:0] O_DMA_AD;
   logic [7:0] O_DMA_DD;
   logic       O_DMA_WED;
   logic       O_BUSY;
   logic       O_DONE;

   sprite_dma_engine dut (
      .I_CLK(clk), .I_RSTn(I_RSTn), .I_DMA_TRIG(I_DMA_TRIG), .I_MODE(I_MODE),
      .I_SRC_BASE(I_SRC_BASE), .I_DST_BASE(I_DST_BASE), .I_LEN(I_LEN),
      .I_FILL(I_FILL), .I_ABORT(I_ABORT), .I_WAIT(I_WAIT), .I_DMA_DS(I_DMA_DS),
      .O_DMA_AS(O_DMA_AS), .O_DMA_CES(O_DMA_CES), .O_DMA_AD(O_DMA_AD),
      .O_DMA_DD(O_DMA_DD), .O_DMA_WED(O_DMA_WED), .O_BUSY(O_BUSY), .O_DONE(O_DONE)
   );

   typedef struct {
      logic [9:0] addr;
      logic [7:0] data;
   } wr_t;

   // w0/w1: edge index after which WAIT is held 5 cycles (0 = none)
   // ab: edge index after which ABORT is pulsed (0 = none, -1 = with trigger)
   // retrig: edge index at which trigger drops, re-rising two cycles later
   typedef struct {
      logic        mode;
      logic [9:0]  src;
      logic [9:0]  dst;
      logic [10:0] len;
      logic [7:0]  fill;
      int          w0, w1, ab, retrig;
      int          exp_wr, exp_ces, exp_cyc;
   } vec_t;

   logic [7:0] src_mem [1024];
   wr_t        exp_q[$];
   vec_t       tbl[9];
   int         total = 0, bad = 0;
   int         wr_cnt = 0, ces_cnt = 0;
   bit         sb_en = 1'b1;

   task automatic check_eq(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Source RAM: data presented after the strobe cycle and held until the next strobe.
   always @(negedge clk) begin
      if (O_DMA_CES) I_DMA_DS = src_mem[O_DMA_AS];
   end

   always @(negedge clk) begin
      wr_t e;
      if (O_DMA_CES) ces_cnt++;
      if (O_DMA_CES || O_DMA_WED) begin
         total++;
         if (O_DMA_CES && O_DMA_WED) begin
            bad++;
            $display("FAIL strobe_overlap: CES and WED both high at %0t", $time);
         end
      end
      if (I_WAIT && O_BUSY) begin
         total++;
         if (O_DMA_CES || O_DMA_WED) begin
            bad++;
            $display("FAIL wait_strobe: ces=%0b wed=%0b while stalled", O_DMA_CES, O_DMA_WED);
         end
      end
      if (O_DMA_WED) begin
         wr_cnt++;
         if (sb_en) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL write_unexpected: addr=0x%0h data=0x%0h want none", O_DMA_AD, O_DMA_DD);
            end else begin
               e = exp_q.pop_front();
               if (O_DMA_AD !== e.addr || O_DMA_DD !== e.data) begin
                  bad++;
                  $display("FAIL write: got addr=0x%0h data=0x%0h want addr=0x%0h data=0x%0h",
                           O_DMA_AD, O_DMA_DD, e.addr, e.data);
               end
            end
         end
      end
   end

   task automatic run_vec(input vec_t v, input int idx);
      int n;
      bit got;
      logic [9:0] sa, da;
      string tag;
      tag = $sformatf("v%0d", idx);
      for (int i = 0; i < v.exp_wr; i++) begin
         sa = v.src + 10'(i);
         da = v.dst + 10'(i);
         exp_q.push_back('{addr: da, data: (v.mode ? v.fill : src_mem[sa])});
      end
      wr_cnt  = 0;
      ces_cnt = 0;
      @(posedge clk); #1;
      I_MODE = v.mode; I_SRC_BASE = v.src; I_DST_BASE = v.dst;
      I_LEN = v.len; I_FILL = v.fill; I_DMA_TRIG = 1'b1;
      I_ABORT = (v.ab < 0);
      n = 0;
      got = 1'b0;
      while (n < v.exp_cyc + 20 && !got) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) begin
            // Config is latched; scrambling it must not affect the transfer.
            I_SRC_BASE = ~v.src; I_DST_BASE = ~v.dst; I_LEN = 11'd3;
            I_FILL = ~v.fill; I_MODE = ~v.mode;
         end
         if (v.retrig > 0) begin
            if (n == v.retrig)     I_DMA_TRIG = 1'b0;
            if (n == v.retrig + 2) I_DMA_TRIG = 1'b1;
         end else if (n == 1) begin
            I_DMA_TRIG = 1'b0;
         end
         I_WAIT  = (v.w0 > 0 && n >= v.w0 && n < v.w0 + 5) ||
                   (v.w1 > 0 && n >= v.w1 && n < v.w1 + 5);
         I_ABORT = (n == v.ab);
         @(negedge clk);
         if (O_DONE) got = 1'b1;
      end
      check_eq({tag, "_done_cycles"}, got ? n : -1, v.exp_cyc);
      check_eq({tag, "_writes"}, wr_cnt, v.exp_wr);
      check_eq({tag, "_reads"}, ces_cnt, v.exp_ces);
      @(posedge clk); #1;
      I_WAIT = 1'b0; I_ABORT = 1'b0;
      @(negedge clk);
      check_eq({tag, "_busy_done_after"}, {30'd0, O_BUSY, O_DONE}, 0);
      check_eq({tag, "_sb_left"}, exp_q.size(), 0);
      exp_q.delete();
      // A trigger still high afterwards is not a new edge.
      repeat (4) @(negedge clk);
      check_eq({tag, "_no_restart"}, {31'd0, O_BUSY} + wr_cnt, v.exp_wr);
      @(posedge clk); #1;
      I_DMA_TRIG = 1'b0;
   endtask

   initial begin
      int dirty;
      for (int i = 0; i < 1024; i++) src_mem[i] = 8'((i * 37 + 11) ^ (i >> 3));

      //         mode  src     dst     len     fill  w0 w1 ab rt  wr   ces  cyc
      tbl[0] = '{1'b0, 10'h100, 10'h000, 11'd384, 8'h00, 0, 0, 0, 0, 384, 384, 3*384+1};
      tbl[1] = '{1'b1, 10'h000, 10'h3FE, 11'd4,   8'hE0, 0, 0, 0, 0, 4,   0,   5};
      tbl[2] = '{1'b0, 10'h123, 10'h045, 11'd0,   8'h00, 0, 0, 0, 0, 0,   0,   1};
      tbl[3] = '{1'b0, 10'h3FE, 10'h3FD, 11'd5,   8'h00, 0, 0, 0, 0, 5,   5,   16};
      tbl[4] = '{1'b0, 10'h200, 10'h080, 11'd12,  8'h00, 7, 29, 0, 0, 12,  12,  37+10};
      tbl[5] = '{1'b0, 10'h040, 10'h300, 11'd32,  8'h00, 0, 0, 32, 0, 10,  11,  33};
      tbl[6] = '{1'b0, 10'h2F0, 10'h1F0, 11'd8,   8'h00, 0, 0, 0, 0, 8,   8,   25};
      tbl[7] = '{1'b0, 10'h010, 10'h020, 11'd6,   8'h00, 0, 0, 0, 3, 6,   6,   19};
      tbl[8] = '{1'b1, 10'h000, 10'h155, 11'd1,   8'h5A, 0, 0, -1, 0, 1,  0,   2};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_outputs", int'({O_DMA_AS, O_DMA_CES, O_DMA_AD, O_DMA_DD,
                                      O_DMA_WED, O_BUSY, O_DONE}), 0);
      @(posedge clk); #1;
      I_RSTn = 1'b1;

      for (int k = 0; k < 9; k++) run_vec(tbl[k], k);

      // Reset mid-transfer with the trigger held high through reset release.
      sb_en  = 1'b0;
      wr_cnt = 0;
      @(posedge clk); #1;
      I_MODE = 1'b0; I_SRC_BASE = 10'h000; I_DST_BASE = 10'h000;
      I_LEN = 11'd20; I_DMA_TRIG = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      I_RSTn = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("midrst_outputs", int'({O_DMA_AS, O_DMA_CES, O_DMA_AD, O_DMA_DD,
                                       O_DMA_WED, O_BUSY, O_DONE}), 0);
      check_eq("midrst_writes", wr_cnt, 3);
      @(posedge clk); #1;
      I_RSTn = 1'b1;
      dirty = 0;
      repeat (6) begin
         @(negedge clk);
         if (O_BUSY || O_DONE) dirty++;
      end
      check_eq("held_trig_no_start", dirty + wr_cnt, 3);
      @(posedge clk); #1;
      I_DMA_TRIG = 1'b0;
      sb_en = 1'b1;

      run_vec(tbl[1], 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_dma_engine.md
Name: sprite_dma_engine

Overview:
Parametrised single-channel DMA engine for sprite/object RAM transfers; successor to the fixed-length sprite copier.
- Source base, destination base, length and mode are latched at trigger time instead of being hard-wired.
- Supports copy and constant-fill modes, bus wait-stall, abort, and busy/done status.
- Sits between CPU-side work RAM (source) and the video sprite buffer (destination); the CPU/bus arbiter drives the trigger and wait inputs.

Parameters:
AS_W, 10, source address width
AD_W, 10, destination address width
D_W, 8, data width
LEN_W, 11, transfer-length width (max 2^LEN_W-1 elements)

Ports:
I_CLK  in  1  system clock
I_RSTn  in  1  synchronous active-low reset
I_DMA_TRIG  in  1  start request, rising-edge sensitive
I_MODE  in  1  0=copy, 1=fill
I_SRC_BASE  in  AS_W  source start address
I_DST_BASE  in  AD_W  destination start address
I_LEN  in  LEN_W  element count
I_FILL  in  D_W  fill value (mode 1)
I_ABORT  in  1  terminate active transfer
I_WAIT  in  1  bus stall; freezes engine while high
I_DMA_DS  in  D_W  source read data, valid the cycle after O_DMA_CES
O_DMA_AS  out  AS_W  source address
O_DMA_CES  out  1  source read strobe
O_DMA_AD  out  AD_W  destination address
O_DMA_DD  out  D_W  destination write data
O_DMA_WED  out  1  destination write strobe
O_BUSY  out  1  transfer in progress
O_DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset: while I_RSTn=0 at a clock edge, the state goes to IDLE.
  - All outputs are 0 after reset.
  - The edge-detect register is cleared. A trigger held high through reset release does not start a transfer.
- Trigger edge: a trigger is accepted in IDLE when I_DMA_TRIG=1 and it was 0 the previous cycle.
  - On accept, latch base addresses, length, mode and fill value. Set element counter=0 and O_BUSY=1 from the next cycle.
  - Edges seen while busy are ignored.
- States: IDLE, READ, LATCH, WRITE, FINISH.
- Copy mode, 3 cycles per element:
  - READ: O_DMA_AS=src_ptr, O_DMA_CES=1.
  - LATCH: capture I_DMA_DS into the data register; CES=0.
  - WRITE: O_DMA_AD=dst_ptr, O_DMA_DD=data, O_DMA_WED=1. Then increment src_ptr, dst_ptr and the counter.
  - If counter+1==len, go to FINISH; else go to READ.
- Fill mode, 1 cycle per element:
  - Stay in WRITE with O_DMA_DD=fill and WED=1 every cycle.
  - Pointers and counter advance as in copy mode. CES stays 0.
- Strobe timing: CES and WED are each high for exactly one cycle per access and are never high in the same cycle.
- FINISH: O_DONE=1 and O_BUSY=0 for one cycle, then return to IDLE.
- LEN=0: go straight from accept to FINISH. No strobes.
- Pointer wrap: pointers wrap modulo 2^AS_W and 2^AD_W, e.g. src 0x3FF→0x000. No error.
- I_WAIT=1 in any non-IDLE state:
  - The state, pointers and counter hold.
  - CES and WED are forced to 0.
  - The stalled access re-issues when WAIT drops.
  - In LATCH, data is captured only in a non-stalled cycle. The source must hold I_DMA_DS while WAIT is high.
- I_ABORT=1 in any non-IDLE state goes to FINISH next cycle; ABORT beats WAIT.
  - The current strobe is suppressed that cycle.
  - O_DONE still pulses.
  - Elements already written stay written.
- Simultaneous events:
  - Abort and trigger edge in IDLE: trigger wins; abort is ignored in IDLE.
  - Reset dominates everything. Reset mid-transfer drops BUSY with no DONE pulse.
- Address/data outputs hold their last values between strobes.

Decomposition:
- Shared package (sprite_dma_pkg): state encodings (3-bit), MODE_COPY/MODE_FILL constants, default widths.
- One natural sub-module: dma_edge_det (rising-edge detector with synchronous clear), reusable by other trigger-driven blocks.
- Datapath and FSM stay in sprite_dma_engine.

Test Plan:
- Copy base 0x100→0x000, LEN=0x180, WAIT=0:
  - 384 WED pulses; dst[i]=src[0x100+i].
  - DONE exactly 3*384+1 cycles after the accepting edge; BUSY low afterwards.
- Fill LEN=4, FILL=0xE0, DST=0x3FE:
  - Writes 0xE0 to 0x3FE, 0x3FF, 0x000, 0x001 on consecutive cycles.
  - No CES; DONE on the following cycle.
- LEN=0 trigger: no CES/WED; DONE pulses one cycle after accept.
- WAIT high 5 cycles in READ of element 2, then in WRITE of element 7:
  - Strobes are absent while stalled.
  - Final memory image is identical to the unstalled run; total time +10 cycles.
- ABORT during LATCH of element 10 (LEN=32):
  - Exactly 10 writes; DONE next cycle.
  - A new trigger edge afterwards starts a fresh transfer from the new bases.
- Reset mid-transfer, and a second trigger edge while busy:
  - Reset: outputs all 0, no DONE.
  - Second edge: ignored, no restart, write count unchanged.
